// File: rtl/fetch_pipeline_controller_if.sv
// fetch_pipeline_controller_if: decode/execute hazard and redirect inputs, fetch control and counter outputs
interface fetch_pipeline_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       DEC_RS1_ADDR;
    logic [4:0]       DEC_RS2_ADDR;
    logic             DEC_USES_RS1;
    logic             DEC_USES_RS2;
    logic [4:0]       EX_RD_ADDR;
    logic             EX_MEM_READ;
    logic             EX_BRANCH_TAKEN;
    logic             EX_JUMP;
    logic [1:0]       EX_PC_SOURCE_REQ;
    logic             PC_WRITE;
    logic [1:0]       PC_SOURCE;
    logic             FETCH_REG_WRITE;
    logic             FETCH_FLUSH;
    logic             DEC_FLUSH;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;
    modport master (
        output DEC_RS1_ADDR, DEC_RS2_ADDR, DEC_USES_RS1, DEC_USES_RS2,
               EX_RD_ADDR, EX_MEM_READ, EX_BRANCH_TAKEN, EX_JUMP, EX_PC_SOURCE_REQ,
        input  PC_WRITE, PC_SOURCE, FETCH_REG_WRITE, FETCH_FLUSH, DEC_FLUSH, STALL_CNT, FLUSH_CNT
    );
    modport slave (
        input  DEC_RS1_ADDR, DEC_RS2_ADDR, DEC_USES_RS1, DEC_USES_RS2,
               EX_RD_ADDR, EX_MEM_READ, EX_BRANCH_TAKEN, EX_JUMP, EX_PC_SOURCE_REQ,
        output PC_WRITE, PC_SOURCE, FETCH_REG_WRITE, FETCH_FLUSH, DEC_FLUSH, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/fetch_pipeline_controller.sv
// fetch_pipeline_controller: fetch-stage PC/flush sequencing with load-use stalls and redirect squashes
module fetch_pipeline_controller #(
    parameter int LOAD_BUBBLES  = 1,
    parameter int FLUSH_BUBBLES = 1,
    parameter int CNT_W         = 16
) (
    input logic CLOCK,
    input logic RESET,
    fetch_pipeline_controller_if.slave bus
);
    localparam logic [1:0] ST_INIT = 2'd0, ST_RUN = 2'd1, ST_STALL = 2'd2, ST_FLUSH = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             redirect, hazard, in_init, in_flush, stall, redir_act;
    always_comb begin
        redirect  = bus.EX_BRANCH_TAKEN | bus.EX_JUMP;
        hazard    = bus.EX_MEM_READ && bus.EX_RD_ADDR != 5'd0 &&
                    ((bus.DEC_USES_RS1 && bus.DEC_RS1_ADDR == bus.EX_RD_ADDR) ||
                     (bus.DEC_USES_RS2 && bus.DEC_RS2_ADDR == bus.EX_RD_ADDR));
        in_init   = state_q == ST_INIT;
        in_flush  = state_q == ST_FLUSH;
        // STALL ignores redirects: execute only holds a bubble there
        redir_act = redirect && (state_q == ST_RUN || in_flush);
        stall     = state_q == ST_STALL || (state_q == ST_RUN && hazard && !redirect);
        bus.PC_WRITE        = !in_init && !stall;
        bus.PC_SOURCE       = redir_act ? bus.EX_PC_SOURCE_REQ : 2'd0;
        bus.FETCH_REG_WRITE = !stall;
        bus.FETCH_FLUSH     = in_init || redir_act || in_flush;
        bus.DEC_FLUSH       = in_init || redir_act || stall;
        bus.STALL_CNT       = stall_cnt_q;
        bus.FLUSH_CNT       = flush_cnt_q;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (redir_act && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_init) begin
            state_d = ST_RUN;
        end else if (redir_act) begin
            state_d = FLUSH_BUBBLES > 0 ? ST_FLUSH : ST_RUN;
            cnt_d   = 3'(FLUSH_BUBBLES);
        end else if (state_q == ST_RUN && hazard) begin
            state_d = LOAD_BUBBLES > 1 ? ST_STALL : ST_RUN;
            cnt_d   = 3'(LOAD_BUBBLES - 1);
        end else if (state_q == ST_STALL || in_flush) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q == 3'd1 ? ST_RUN : state_q;
        end
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_pipeline_controller.sv
// tb_fetch_pipeline_controller: three parameterisations driven in lockstep, checked by a table and a bubble-count model
module tb_fetch_pipeline_controller;
    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, bt, j;
        logic [1:0] req;
        logic       chk;
        logic [5:0] exp;
        int         scnt, fcnt;
    } vec_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int tests = 0, fails = 0;

    fetch_pipeline_controller_if #(.CNT_W(16)) ifa();
    fetch_pipeline_controller_if #(.CNT_W(3))  ifb();
    fetch_pipeline_controller_if #(.CNT_W(8))  ifc();
    fetch_pipeline_controller #(.LOAD_BUBBLES(1), .FLUSH_BUBBLES(1), .CNT_W(16)) dut_a (.CLOCK(CLOCK), .RESET(RESET), .bus(ifa));
    fetch_pipeline_controller #(.LOAD_BUBBLES(3), .FLUSH_BUBBLES(0), .CNT_W(3))  dut_b (.CLOCK(CLOCK), .RESET(RESET), .bus(ifb));
    fetch_pipeline_controller #(.LOAD_BUBBLES(2), .FLUSH_BUBBLES(2), .CNT_W(8))  dut_c (.CLOCK(CLOCK), .RESET(RESET), .bus(ifc));

    always #5 CLOCK = ~CLOCK;

    int  lbp[3]  = '{1, 3, 2};
    int  fbp[3]  = '{1, 0, 2};
    int  cmax[3] = '{65535, 7, 255};
    bit  m_init[3];
    int  m_stall[3], m_flush[3], m_scnt[3], m_fcnt[3];

    function automatic vec_t mk(int rst, int rs1, int rs2, int rd, int u1, int u2, int mr,
                                int bt, int j, int req, int chk, logic [5:0] exp, int sc, int fc);
        vec_t v;
        v.rst = 1'(rst); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.u1 = 1'(u1); v.u2 = 1'(u2); v.mr = 1'(mr); v.bt = 1'(bt); v.j = 1'(j);
        v.req = 2'(req); v.chk = 1'(chk); v.exp = exp; v.scnt = sc; v.fcnt = fc;
        return v;
    endfunction

    function automatic bit haz(vec_t v);
        return v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    endfunction

    function automatic bit redir(vec_t v);
        return v.bt || v.j;
    endfunction

    // Expected {PC_WRITE, PC_SOURCE, FETCH_REG_WRITE, FETCH_FLUSH, DEC_FLUSH} from remaining bubble counts
    function automatic logic [5:0] predict(int k, vec_t v);
        if (m_init[k]) return 6'b000111;
        if (m_stall[k] > 0) return 6'b000001;
        if (redir(v)) return {1'b1, v.req, 3'b111};
        if (m_flush[k] > 0) return 6'b100110;
        if (haz(v)) return 6'b000001;
        return 6'b100100;
    endfunction

    task automatic model_step(int k, vec_t v);
        if (v.rst) begin
            m_init[k] = 1; m_stall[k] = 0; m_flush[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end else if (m_init[k]) begin
            m_init[k] = 0;
        end else if (m_stall[k] > 0) begin
            m_stall[k]--;
            if (m_scnt[k] < cmax[k]) m_scnt[k]++;
        end else if (redir(v)) begin
            m_flush[k] = fbp[k];
            if (m_fcnt[k] < cmax[k]) m_fcnt[k]++;
        end else if (m_flush[k] > 0) begin
            m_flush[k]--;
        end else if (haz(v)) begin
            m_stall[k] = lbp[k] - 1;
            if (m_scnt[k] < cmax[k]) m_scnt[k]++;
        end
    endtask

    function automatic logic [5:0] dut_out(int k);
        case (k)
            0: return {ifa.PC_WRITE, ifa.PC_SOURCE, ifa.FETCH_REG_WRITE, ifa.FETCH_FLUSH, ifa.DEC_FLUSH};
            1: return {ifb.PC_WRITE, ifb.PC_SOURCE, ifb.FETCH_REG_WRITE, ifb.FETCH_FLUSH, ifb.DEC_FLUSH};
            default: return {ifc.PC_WRITE, ifc.PC_SOURCE, ifc.FETCH_REG_WRITE, ifc.FETCH_FLUSH, ifc.DEC_FLUSH};
        endcase
    endfunction

    function automatic int dut_scnt(int k);
        return k == 0 ? int'(ifa.STALL_CNT) : k == 1 ? int'(ifb.STALL_CNT) : int'(ifc.STALL_CNT);
    endfunction

    function automatic int dut_fcnt(int k);
        return k == 0 ? int'(ifa.FLUSH_CNT) : k == 1 ? int'(ifb.FLUSH_CNT) : int'(ifc.FLUSH_CNT);
    endfunction

    task automatic expect_eq(string nm, int got, int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(vec_t v);
        RESET = v.rst;
        ifa.DEC_RS1_ADDR = v.rs1; ifa.DEC_RS2_ADDR = v.rs2; ifa.DEC_USES_RS1 = v.u1; ifa.DEC_USES_RS2 = v.u2;
        ifa.EX_RD_ADDR = v.rd; ifa.EX_MEM_READ = v.mr; ifa.EX_BRANCH_TAKEN = v.bt; ifa.EX_JUMP = v.j; ifa.EX_PC_SOURCE_REQ = v.req;
        ifb.DEC_RS1_ADDR = v.rs1; ifb.DEC_RS2_ADDR = v.rs2; ifb.DEC_USES_RS1 = v.u1; ifb.DEC_USES_RS2 = v.u2;
        ifb.EX_RD_ADDR = v.rd; ifb.EX_MEM_READ = v.mr; ifb.EX_BRANCH_TAKEN = v.bt; ifb.EX_JUMP = v.j; ifb.EX_PC_SOURCE_REQ = v.req;
        ifc.DEC_RS1_ADDR = v.rs1; ifc.DEC_RS2_ADDR = v.rs2; ifc.DEC_USES_RS1 = v.u1; ifc.DEC_USES_RS2 = v.u2;
        ifc.EX_RD_ADDR = v.rd; ifc.EX_MEM_READ = v.mr; ifc.EX_BRANCH_TAKEN = v.bt; ifc.EX_JUMP = v.j; ifc.EX_PC_SOURCE_REQ = v.req;
    endtask

    // One clock: drive, check at negedge, advance the model at the rising edge
    task automatic cycle(vec_t v, int row);
        drive(v);
        @(negedge CLOCK);
        if (v.chk) begin
            tests++;
            if (dut_out(0) !== v.exp) begin
                fails++;
                $display("FAIL table[%0d] outputs got %b expected %b", row, dut_out(0), v.exp);
            end
            tests++;
            if (dut_scnt(0) !== v.scnt || dut_fcnt(0) !== v.fcnt) begin
                fails++;
                $display("FAIL table[%0d] counters got %0d/%0d expected %0d/%0d", row, dut_scnt(0), dut_fcnt(0), v.scnt, v.fcnt);
            end
        end
        if (!v.rst) begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (dut_out(k) !== predict(k, v)) begin
                    fails++;
                    $display("FAIL model_out dut%0d got %b expected %b", k, dut_out(k), predict(k, v));
                end
                tests++;
                if (dut_scnt(k) !== m_scnt[k] || dut_fcnt(k) !== m_fcnt[k]) begin
                    fails++;
                    $display("FAIL model_cnt dut%0d got %0d/%0d expected %0d/%0d", k, dut_scnt(k), dut_fcnt(k), m_scnt[k], m_fcnt[k]);
                end
            end
        end
        @(posedge CLOCK);
        for (int k = 0; k < 3; k++) model_step(k, v);
        #1;
    endtask

    vec_t tbl[16];
    vec_t idle, hz, rv;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0);
        hz   = mk(0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 6'b0, 0, 0);
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000111, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100100, 0, 0);
        tbl[3]  = mk(0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 1, 6'b000001, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100100, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 6'b100100, 1, 0);
        tbl[6]  = mk(0, 3, 5, 5, 1, 0, 1, 0, 0, 0, 1, 6'b100100, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 6'b111111, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100110, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100100, 1, 1);
        tbl[10] = mk(0, 0, 5, 5, 0, 1, 1, 1, 0, 2, 1, 6'b110111, 1, 1);
        tbl[11] = mk(0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 1, 6'b100110, 1, 2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100100, 1, 2);
        tbl[13] = mk(0, 7, 0, 7, 1, 0, 1, 0, 0, 0, 1, 6'b000001, 1, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100100, 2, 2);
        tbl[15] = mk(0, 4, 0, 4, 1, 0, 0, 0, 0, 0, 1, 6'b100100, 2, 2);
        for (int i = 0; i < 16; i++) cycle(tbl[i], i);

        // LOAD_BUBBLES=3 gives three stall cycles per hazard
        cycle(tbl[0], -1); cycle(idle, -1); cycle(idle, -1);
        cycle(hz, -1); cycle(idle, -1); cycle(idle, -1);
        expect_eq("stall3_cnt_b", int'(ifb.STALL_CNT), 3);
        expect_eq("stall3_pcw_b", int'(ifb.PC_WRITE), 1);
        expect_eq("stall1_cnt_a", int'(ifa.STALL_CNT), 1);
        expect_eq("stall2_cnt_c", int'(ifc.STALL_CNT), 2);

        // Nine more events saturate the 3-bit counter at 7
        for (int i = 0; i < 9; i++) begin
            cycle(hz, -1); cycle(idle, -1); cycle(idle, -1);
        end
        expect_eq("sat_cnt_b", int'(ifb.STALL_CNT), 7);
        expect_eq("sat_cnt_c", int'(ifc.STALL_CNT), 20);
        expect_eq("sat_cnt_a", int'(ifa.STALL_CNT), 10);

        // Reset while dut_b is mid-stall
        cycle(hz, -1);
        expect_eq("mid_stall_pcw_b", int'(ifb.PC_WRITE), 0);
        cycle(tbl[0], -1);
        expect_eq("rst_stall_pcw_b", int'(ifb.PC_WRITE), 0);
        expect_eq("rst_stall_ff_b", int'(ifb.FETCH_FLUSH), 1);
        expect_eq("rst_stall_cnt_b", int'(ifb.STALL_CNT), 0);

        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(99) == 0) ? 1 : 0,
                    $urandom_range(3), $urandom_range(3), $urandom_range(3),
                    $urandom_range(1), $urandom_range(1), $urandom_range(1),
                    ($urandom_range(9) == 0) ? 1 : 0, ($urandom_range(9) == 0) ? 1 : 0,
                    $urandom_range(3), 0, 6'b0, 0, 0);
            cycle(rv, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_pipeline_controller.md
Name: fetch_pipeline_controller

Overview:
- Sequences the instruction fetch stage: drives PC write-enable, PC mux select, fetch-register write-enable and squash controls.
- Detects load-use hazards between decode and execute, and applies branch/jump redirects resolved in execute.
- Inserts the bubbles the synchronous instruction memory needs after reset and after each redirect.
- Sits beside the fetch stage; its outputs feed PC_WRITE/PC_SOURCE of the fetch stage and the flush/enable pins of the fetch and decode pipeline registers.

Parameters:
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..4).
- FLUSH_BUBBLES, 1: extra fetch-squash cycles after a redirect, covering memory read latency (0..4).
- CNT_W, 16: width of the saturating performance counters.

Ports:
- CLOCK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- DEC_RS1_ADDR  in  5  rs1 of the instruction in decode
- DEC_RS2_ADDR  in  5  rs2 of the instruction in decode
- DEC_USES_RS1  in  1  decode instruction reads rs1
- DEC_USES_RS2  in  1  decode instruction reads rs2
- EX_RD_ADDR  in  5  rd of the instruction in execute
- EX_MEM_READ  in  1  execute instruction is a load
- EX_BRANCH_TAKEN  in  1  conditional branch in execute resolved taken
- EX_JUMP  in  1  JAL/JALR in execute
- EX_PC_SOURCE_REQ  in  2  PC mux select for the redirect (1=JALR, 2=BRANCH, 3=JAL)
- PC_WRITE  out  1  PC register enable
- PC_SOURCE  out  2  PC mux select (0=PC+4)
- FETCH_REG_WRITE  out  1  fetch pipeline register enable
- FETCH_FLUSH  out  1  load NOP into the fetch register
- DEC_FLUSH  out  1  load NOP into the decode/execute register
- STALL_CNT  out  CNT_W  count of hazard stall cycles
- FLUSH_CNT  out  CNT_W  count of redirect events

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. Counters are registered.
- Signal definitions:
  - redirect = EX_BRANCH_TAKEN | EX_JUMP.
  - hazard = EX_MEM_READ & (EX_RD_ADDR != 0) & ((DEC_USES_RS1 & DEC_RS1_ADDR == EX_RD_ADDR) | (DEC_USES_RS2 & DEC_RS2_ADDR == EX_RD_ADDR)).
- States: INIT, RUN, STALL, FLUSH. An internal bubble counter is 3 bits wide.
- RESET high: next state INIT, both counters 0. This applies from any state, mid-stall or mid-flush included.
- INIT, held exactly 1 cycle: PC_WRITE=0, PC_SOURCE=0, FETCH_REG_WRITE=1, FETCH_FLUSH=1, DEC_FLUSH=1. Next state RUN. The first PC advance therefore occurs on the second edge after RESET deasserts.
- RUN, default: PC_WRITE=1, PC_SOURCE=0, FETCH_REG_WRITE=1, flushes 0.
- RUN, redirect (takes priority over hazard):
  - PC_WRITE=1, PC_SOURCE=EX_PC_SOURCE_REQ, FETCH_FLUSH=1, DEC_FLUSH=1.
  - FLUSH_CNT increments.
  - Next state FLUSH with counter=FLUSH_BUBBLES if FLUSH_BUBBLES>0, else RUN.
- RUN, hazard and no redirect:
  - PC_WRITE=0, FETCH_REG_WRITE=0, DEC_FLUSH=1, FETCH_FLUSH=0.
  - STALL_CNT increments.
  - Next state STALL with counter=LOAD_BUBBLES-1 if LOAD_BUBBLES>1, else RUN.
- STALL: outputs as in a RUN hazard cycle, STALL_CNT increments each cycle. Counter decrements; exit to RUN when it reaches 0. Redirect inputs are ignored in STALL (execute holds a bubble).
- FLUSH: PC_WRITE=1, PC_SOURCE=0, FETCH_REG_WRITE=1, FETCH_FLUSH=1, DEC_FLUSH=0. Counter decrements; exit to RUN after the counter reaches 0. A redirect in FLUSH is handled exactly as a redirect in RUN: it reloads the counter and increments FLUSH_CNT.
- Counters saturate at all-ones and never wrap.
- EX_PC_SOURCE_REQ is don't-care when redirect=0. PC_SOURCE never takes a non-zero value without PC_WRITE=1.

Test Plan:
- Reset release → INIT cycle with PC_WRITE=0, FETCH_FLUSH=1; next cycle PC_WRITE=1, PC_SOURCE=0; counters 0.
- EX_MEM_READ=1, EX_RD_ADDR=5, DEC_RS2_ADDR=5, DEC_USES_RS2=1 → one cycle with PC_WRITE=0, FETCH_REG_WRITE=0, DEC_FLUSH=1; STALL_CNT=1; repeat with LOAD_BUBBLES=3 → 3 stall cycles, STALL_CNT=3.
- Same hazard but EX_RD_ADDR=0, or DEC_USES_RS2=0 → no stall, PC_WRITE=1.
- EX_JUMP=1, EX_PC_SOURCE_REQ=3 → PC_SOURCE=3, FETCH_FLUSH=DEC_FLUSH=1; next cycle FLUSH (FETCH_FLUSH=1, PC_SOURCE=0); FLUSH_CNT=1.
- Hazard and EX_BRANCH_TAKEN=1 in the same cycle → redirect wins: PC_WRITE=1, PC_SOURCE=2, STALL_CNT unchanged.
- CNT_W=3, 9 stall events → STALL_CNT holds 7; RESET asserted in STALL → next cycle INIT, counters 0.
